// File: rtl/spi_collector_pkg.sv
// Shared types for the SPI frame collector: FSM phases, flag indices and
// the packet bundle seen on the monitor side.
package spi_collector_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    TAIL
  } phase_e;

  localparam int FLAG_SHORT = 0;
  localparam int FLAG_LONG  = 1;

  localparam int PKT_CMD_W  = 32;
  localparam int PKT_ADDR_W = 32;
  localparam int PKT_DATA_W = 32;
  localparam int PKT_CNT_W  = 16;

  typedef struct packed {
    logic [PKT_CMD_W-1:0]  cmd;
    logic [PKT_ADDR_W-1:0] addr;
    logic [PKT_DATA_W-1:0] data;
    logic [1:0]            flag;
    logic [PKT_CNT_W-1:0]  bit_cnt;
  } pkt_t;

endpackage

// File: rtl/spi_frame_collector_if.sv
// Valid/ready packet bundle from the collector to a monitor-side consumer.
// master = collector, slave = consumer.
interface spi_frame_collector_if #(
  parameter int CMD_W  = 32,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              pkt_valid;
  logic              pkt_ready;
  logic [CMD_W-1:0]  pkt_cmd;
  logic [ADDR_W-1:0] pkt_addr;
  logic [DATA_W-1:0] pkt_data;
  logic [1:0]        pkt_flag;
  logic [CNT_W-1:0]  pkt_bit_cnt;

  modport master (
    output pkt_valid,
    output pkt_cmd,
    output pkt_addr,
    output pkt_data,
    output pkt_flag,
    output pkt_bit_cnt,
    input  pkt_ready
  );

  modport slave (
    input  pkt_valid,
    input  pkt_cmd,
    input  pkt_addr,
    input  pkt_data,
    input  pkt_flag,
    input  pkt_bit_cnt,
    output pkt_ready
  );
endinterface

// File: rtl/spi_pin_sync.sv
// Pin synchroniser for sclk/csn/data lanes with edge pulses on the
// synced sclk and csn. Data lanes get the same depth so they stay aligned.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int DW          = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_sclk,
  input  logic          i_csn,
  input  logic [DW-1:0] i_dat,
  output logic [DW-1:0] o_dat,
  output logic          o_sclk_rise,
  output logic          o_csn_rise,
  output logic          o_csn_fall
);

  logic [SYNC_STAGES-1:0]         r_sclk;
  logic [SYNC_STAGES-1:0]         r_csn;
  logic [SYNC_STAGES-1:0][DW-1:0] r_dat;
  logic                           r_sclk_d;
  logic                           r_csn_d;

  // Reset to 0 so a csn held low across reset never looks like a fall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sclk   <= '0;
      r_csn    <= '0;
      r_dat    <= '0;
      r_sclk_d <= 1'b0;
      r_csn_d  <= 1'b0;
    end else begin
      r_sclk   <= {r_sclk[SYNC_STAGES-2:0], i_sclk};
      r_csn    <= {r_csn[SYNC_STAGES-2:0], i_csn};
      r_dat    <= {r_dat[SYNC_STAGES-2:0], i_dat};
      r_sclk_d <= r_sclk[SYNC_STAGES-1];
      r_csn_d  <= r_csn[SYNC_STAGES-1];
    end
  end

  assign o_dat       = r_dat[SYNC_STAGES-1];
  assign o_sclk_rise = r_sclk[SYNC_STAGES-1] & ~r_sclk_d;
  assign o_csn_rise  = r_csn[SYNC_STAGES-1] & ~r_csn_d;
  assign o_csn_fall  = ~r_csn[SYNC_STAGES-1] & r_csn_d;

endmodule

// File: rtl/spi_frame_collector.sv
// Snoops SPI mode-0 pins and rebuilds each csn frame into cmd/addr/data.
// SPI_FRAME_COLLECTOR_QUAD_EN adds a 4-lane sdio capture mode.
module spi_frame_collector
  import spi_collector_pkg::*;
#(
  parameter int CMD_W       = 32,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 6,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [LEN_W-1:0] cfg_cmd_len,
  input  logic [LEN_W-1:0] cfg_addr_len,
  input  logic [LEN_W-1:0] cfg_data_len,
`ifdef SPI_FRAME_COLLECTOR_QUAD_EN
  input  logic             cfg_quad,
  input  logic [3:0]       spi_sdio,
`endif
  input  logic             spi_sclk,
  input  logic             spi_csn,
  input  logic             spi_mosi,
  spi_frame_collector_if.master pkt,
  output logic [7:0]       drop_cnt,
  output logic             busy
);

  localparam int PW  = LEN_W + 1;
  localparam int CW1 = CNT_W + 1;
`ifdef SPI_FRAME_COLLECTOR_QUAD_EN
  localparam int DW = 5;
`else
  localparam int DW = 1;
`endif

  function automatic logic [PW-1:0] f_eff(
    input logic [LEN_W-1:0] len,
    input int               w,
    input logic             q
  );
    int l;
    l = int'(len);
    if (l > w) l = w;
    if (q) l = (l + 3) / 4 * 4;
    return PW'(l);
  endfunction

  logic [DW-1:0] w_pin_dat;
  logic [DW-1:0] w_dat;
  logic          w_sclk_rise;
  logic          w_csn_rise;
  logic          w_csn_fall;
  logic          w_qc;
  logic          w_q;
  logic [3:0]    w_nib;

`ifdef SPI_FRAME_COLLECTOR_QUAD_EN
  logic r_quad;
  assign w_pin_dat = {spi_sdio, spi_mosi};
  assign w_qc      = cfg_quad;
  assign w_q       = r_quad;
  assign w_nib     = w_dat[4:1];
`else
  assign w_pin_dat = spi_mosi;
  assign w_qc      = 1'b0;
  assign w_q       = 1'b0;
  assign w_nib     = 4'd0;
`endif

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .DW         (DW)
  ) u_sync (
    .clk        (clk),
    .rstn       (rstn),
    .i_sclk     (spi_sclk),
    .i_csn      (spi_csn),
    .i_dat      (w_pin_dat),
    .o_dat      (w_dat),
    .o_sclk_rise(w_sclk_rise),
    .o_csn_rise (w_csn_rise),
    .o_csn_fall (w_csn_fall)
  );

  phase_e            r_state;
  logic [PW-1:0]     r_len_c;
  logic [PW-1:0]     r_len_a;
  logic [PW-1:0]     r_len_d;
  logic [PW-1:0]     r_pcnt;
  logic [CMD_W-1:0]  r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_long;

  logic [PW-1:0]     w_len_c;
  logic [PW-1:0]     w_len_a;
  logic [PW-1:0]     w_len_d;
  phase_e            w_first;
  phase_e            w_after_cmd;
  phase_e            w_after_addr;
  logic [PW-1:0]     w_step;
  logic [CW1-1:0]    w_cstep;
  logic [PW-1:0]     w_pc_inc;
  logic [CW1-1:0]    w_cnt_sum;
  logic [CMD_W-1:0]  w_cmd_sh;
  logic [ADDR_W-1:0] w_addr_sh;
  logic [DATA_W-1:0] w_data_sh;

  phase_e            w_state_nx;
  logic [PW-1:0]     w_pcnt_nx;
  logic [CMD_W-1:0]  w_cmd_nx;
  logic [ADDR_W-1:0] w_addr_nx;
  logic [DATA_W-1:0] w_data_nx;
  logic [CNT_W-1:0]  w_cnt_nx;
  logic              w_long_nx;
  logic [1:0]        w_flag;
  logic              w_emit;
  logic              w_hs;

  assign w_len_c = f_eff(cfg_cmd_len, CMD_W, w_qc);
  assign w_len_a = f_eff(cfg_addr_len, ADDR_W, w_qc);
  assign w_len_d = f_eff(cfg_data_len, DATA_W, w_qc);

  assign w_first = (w_len_c != '0) ? CMD  :
                   (w_len_a != '0) ? ADDR :
                   (w_len_d != '0) ? DATA : TAIL;
  assign w_after_cmd  = (r_len_a != '0) ? ADDR :
                        (r_len_d != '0) ? DATA : TAIL;
  assign w_after_addr = (r_len_d != '0) ? DATA : TAIL;

  assign w_step    = w_q ? PW'(4) : PW'(1);
  assign w_cstep   = w_q ? CW1'(4) : CW1'(1);
  assign w_pc_inc  = r_pcnt + w_step;
  assign w_cnt_sum = {1'b0, r_cnt} + w_cstep;

  // Quad bits beyond the field width fall off the top of the shift.
  assign w_cmd_sh  = w_q ? CMD_W'({r_cmd, w_nib})
                         : CMD_W'({r_cmd, w_dat[0]});
  assign w_addr_sh = w_q ? ADDR_W'({r_addr, w_nib})
                         : ADDR_W'({r_addr, w_dat[0]});
  assign w_data_sh = w_q ? DATA_W'({r_data, w_nib})
                         : DATA_W'({r_data, w_dat[0]});

  // Post-bit view of the frame, so a same-cycle csn rise emits it.
  always_comb begin
    w_state_nx = r_state;
    w_pcnt_nx  = r_pcnt;
    w_cmd_nx   = r_cmd;
    w_addr_nx  = r_addr;
    w_data_nx  = r_data;
    w_cnt_nx   = r_cnt;
    w_long_nx  = r_long;
    if (w_sclk_rise && (r_state != IDLE)) begin
      w_cnt_nx = w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
      unique case (r_state)
        CMD: begin
          w_cmd_nx  = w_cmd_sh;
          w_pcnt_nx = w_pc_inc;
          if (w_pc_inc >= r_len_c) begin
            w_state_nx = w_after_cmd;
            w_pcnt_nx  = '0;
          end
        end
        ADDR: begin
          w_addr_nx = w_addr_sh;
          w_pcnt_nx = w_pc_inc;
          if (w_pc_inc >= r_len_a) begin
            w_state_nx = w_after_addr;
            w_pcnt_nx  = '0;
          end
        end
        DATA: begin
          w_data_nx = w_data_sh;
          w_pcnt_nx = w_pc_inc;
          if (w_pc_inc >= r_len_d) begin
            w_state_nx = TAIL;
            w_pcnt_nx  = '0;
          end
        end
        TAIL:    w_long_nx = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_flag             = '0;
    w_flag[FLAG_SHORT] = (w_state_nx != TAIL);
    w_flag[FLAG_LONG]  = w_long_nx;
  end

  assign w_emit = w_csn_rise && (r_state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_len_c <= '0;
      r_len_a <= '0;
      r_len_d <= '0;
      r_pcnt  <= '0;
      r_cmd   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_long  <= 1'b0;
`ifdef SPI_FRAME_COLLECTOR_QUAD_EN
      r_quad  <= 1'b0;
`endif
    end else if (r_state == IDLE) begin
      if (w_csn_fall) begin
        r_state <= w_first;
        r_len_c <= w_len_c;
        r_len_a <= w_len_a;
        r_len_d <= w_len_d;
        r_pcnt  <= '0;
        r_cmd   <= '0;
        r_addr  <= '0;
        r_data  <= '0;
        r_cnt   <= '0;
        r_long  <= 1'b0;
`ifdef SPI_FRAME_COLLECTOR_QUAD_EN
        r_quad  <= cfg_quad;
`endif
      end
    end else begin
      r_state <= w_csn_rise ? IDLE : w_state_nx;
      r_pcnt  <= w_pcnt_nx;
      r_cmd   <= w_cmd_nx;
      r_addr  <= w_addr_nx;
      r_data  <= w_data_nx;
      r_cnt   <= w_cnt_nx;
      r_long  <= w_long_nx;
    end
  end

  logic              r_valid;
  logic [CMD_W-1:0]  r_pk_cmd;
  logic [ADDR_W-1:0] r_pk_addr;
  logic [DATA_W-1:0] r_pk_data;
  logic [1:0]        r_pk_flag;
  logic [CNT_W-1:0]  r_pk_cnt;
  logic [7:0]        r_drop;

  assign w_hs = r_valid & pkt.pkt_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid   <= 1'b0;
      r_pk_cmd  <= '0;
      r_pk_addr <= '0;
      r_pk_data <= '0;
      r_pk_flag <= '0;
      r_pk_cnt  <= '0;
      r_drop    <= '0;
    end else if (w_emit && (!r_valid || w_hs)) begin
      r_valid   <= 1'b1;
      r_pk_cmd  <= w_cmd_nx;
      r_pk_addr <= w_addr_nx;
      r_pk_data <= w_data_nx;
      r_pk_flag <= w_flag;
      r_pk_cnt  <= w_cnt_nx;
    end else begin
      if (w_emit && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
      if (w_hs) r_valid <= 1'b0;
    end
  end

  assign pkt.pkt_valid   = r_valid;
  assign pkt.pkt_cmd     = r_pk_cmd;
  assign pkt.pkt_addr    = r_pk_addr;
  assign pkt.pkt_data    = r_pk_data;
  assign pkt.pkt_flag    = r_pk_flag;
  assign pkt.pkt_bit_cnt = r_pk_cnt;
  assign drop_cnt        = r_drop;
  assign busy            = (r_state != IDLE);

endmodule

// File: tb/tb_spi_frame_collector.sv
// Directed bench for spi_frame_collector with a packet scoreboard.
// Default build (single lane).
module tb_spi_frame_collector;
  import spi_collector_pkg::*;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] cfg_c, cfg_a, cfg_d;
  logic       sclk, csn, mosi;
  logic [7:0] drop_cnt;
  logic       busy;

  spi_frame_collector_if pkt_if ();

  spi_frame_collector #(.SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cfg_cmd_len (cfg_c),
    .cfg_addr_len(cfg_a),
    .cfg_data_len(cfg_d),
    .spi_sclk    (sclk),
    .spi_csn     (csn),
    .spi_mosi    (mosi),
    .pkt         (pkt_if),
    .drop_cnt    (drop_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  pkt_t sb[$];
  pkt_t mon_obs, mon_exp;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t mk(input logic [31:0] c, input logic [31:0] a,
                              input logic [31:0] d, input logic [1:0] f,
                              input logic [15:0] n);
    pkt_t p;
    p.cmd = c;
    p.addr = a;
    p.data = d;
    p.flag = f;
    p.bit_cnt = n;
    return p;
  endfunction

  always @(negedge clk) begin
    if (rstn && pkt_if.pkt_valid && pkt_if.pkt_ready) begin
      mon_obs.cmd     = pkt_if.pkt_cmd;
      mon_obs.addr    = pkt_if.pkt_addr;
      mon_obs.data    = pkt_if.pkt_data;
      mon_obs.flag    = pkt_if.pkt_flag;
      mon_obs.bit_cnt = pkt_if.pkt_bit_cnt;
      chk("pkt_expected", 128'(sb.size() != 0), 128'd1);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        chk("pkt", 128'(mon_obs), 128'(mon_exp));
      end
    end
  end

  task automatic set_cfg(input int c, input int a, input int d);
    cfg_c = 6'(c);
    cfg_a = 6'(a);
    cfg_d = 6'(d);
  endtask

  task automatic frame_start();
    @(negedge clk);
    csn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input logic [127:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic frame_end();
    repeat (4) @(negedge clk);
    csn = 1'b1;
  endtask

  task automatic gap();
    repeat (12) @(negedge clk);
  endtask

  task automatic frame(input logic [127:0] v, input int n);
    frame_start();
    send_bits(v, n);
    frame_end();
    gap();
  endtask

  int lat;

  initial begin
    rstn = 1'b0;
    csn = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    pkt_if.pkt_ready = 1'b1;
    set_cfg(0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_valid", 128'(pkt_if.pkt_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_drop", 128'(drop_cnt), 128'd0);
    chk("rst_bitcnt", 128'(pkt_if.pkt_bit_cnt), 128'd0);
    chk("rst_cmd", 128'(pkt_if.pkt_cmd), 128'd0);
    rstn = 1'b1;
    gap();

    // exact frame 8/24/32 with emit latency
    set_cfg(8, 24, 32);
    sb.push_back(mk(32'hA5, 32'h123456, 32'hDEADBEEF, 2'b00, 16'd64));
    frame_start();
    send_bits({64'd0, 8'hA5, 24'h123456, 32'hDEADBEEF}, 64);
    chk("busy_mid", 128'(busy), 128'd1);
    frame_end();
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!pkt_if.pkt_valid && lat < 20);
    chk("emit_latency", 128'(lat), 128'(SYNC + 1));
    gap();

    // skipped addr phase
    set_cfg(8, 0, 16);
    sb.push_back(mk(32'h3C, 32'h0, 32'hBEEF, 2'b00, 16'd24));
    frame({104'd0, 8'h3C, 16'hBEEF}, 24);

    // short frame
    set_cfg(8, 8, 8);
    sb.push_back(mk(32'h81, 32'h0F, 32'h0, 2'b01, 16'd12));
    frame({116'd0, 8'h81, 4'hF}, 12);

    // long frame
    sb.push_back(mk(32'h11, 32'h22, 32'h33, 2'b10, 16'd30));
    frame({98'd0, 8'h11, 8'h22, 8'h33, 6'h2A}, 30);

    // backpressure: first packet held, two drops
    pkt_if.pkt_ready = 1'b0;
    sb.push_back(mk(32'hA1, 32'hB2, 32'hC3, 2'b00, 16'd24));
    frame({104'd0, 8'hA1, 8'hB2, 8'hC3}, 24);
    frame({104'd0, 8'h01, 8'h02, 8'h03}, 24);
    frame({104'd0, 8'h04, 8'h05, 8'h06}, 24);
    chk("bp_drop", 128'(drop_cnt), 128'd2);
    chk("bp_valid", 128'(pkt_if.pkt_valid), 128'd1);
    chk("bp_cmd_held", 128'(pkt_if.pkt_cmd), 128'hA1);
    chk("bp_data_held", 128'(pkt_if.pkt_data), 128'hC3);
    @(posedge clk);
    #2 pkt_if.pkt_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_valid_clear", 128'(pkt_if.pkt_valid), 128'd0);
    gap();

    // reset mid-frame
    frame_start();
    send_bits(128'h2AB, 10);
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst_busy", 128'(busy), 128'd0);
    chk("mrst_valid", 128'(pkt_if.pkt_valid), 128'd0);
    chk("mrst_drop", 128'(drop_cnt), 128'd0);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    frame_end();
    gap();
    chk("mrst_no_pkt", 128'(pkt_if.pkt_valid), 128'd0);
    chk("mrst_idle", 128'(busy), 128'd0);
    sb.push_back(mk(32'hC3, 32'h5A, 32'h96, 2'b00, 16'd24));
    frame({104'd0, 8'hC3, 8'h5A, 8'h96}, 24);
    gap();

    chk("sb_drained", 128'(sb.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
